// File: rtl/mem_stage.sv
// Memory-access stage: turns ex_mem load/store controls into req/ack RAM transactions,
// extends load data for mem_wb and stalls upstream while an access is in flight.
module mem_stage #(
   parameter int ADDR_WIDTH     = 30,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_ex_mem,
   input  logic                  MemRead_ex_mem,
   input  logic                  MemWrite_ex_mem,
   input  logic [1:0]            mem_size_ex_mem,
   input  logic                  mem_unsigned_ex_mem,
   input  logic                  halt_ex_mem,
   input  logic [31:0]           alu_out_ex_mem,
   input  logic [31:0]           ram_write_data_ex_mem,
   output logic                  ram_req,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [3:0]            ram_be,
   output logic [31:0]           ram_wdata,
   input  logic                  ram_ack,
   input  logic [31:0]           ram_rdata,
   output logic [31:0]           ram_read_data_mem,
   output logic                  mem_stall,
   output logic                  mem_misaligned,
   output logic                  mem_bus_error
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_load;
   logic             r_uns;
   logic [1:0]       r_size;
   logic [1:0]       r_off;

   logic             w_access;
   logic             w_mis;
   logic             w_start;
   logic             w_timeout;
   logic [3:0]       w_be;
   logic [31:0]      w_wdata;
   logic [7:0]       w_byte;
   logic [15:0]      w_half;
   logic [31:0]      w_ext;

   assign w_access = MemRead_ex_mem | MemWrite_ex_mem;
   // Reserved size 2'b11 is handled as a word, hence the test on size[1] alone.
   assign w_mis = ((mem_size_ex_mem == 2'b01) & alu_out_ex_mem[0]) |
                  (mem_size_ex_mem[1] & (alu_out_ex_mem[1:0] != 2'b00));
   assign mem_misaligned = (r_state == StIdle) & valid_ex_mem & w_access & w_mis;
   assign w_start = (r_state == StIdle) & valid_ex_mem & w_access & ~halt_ex_mem &
                    ~mem_misaligned;
   assign mem_stall = w_start | (r_state == StWait);
   assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = ram_write_data_ex_mem;
      if (mem_size_ex_mem == 2'b00) begin
         w_be    = 4'b0001 << alu_out_ex_mem[1:0];
         w_wdata = {4{ram_write_data_ex_mem[7:0]}};
      end else if (mem_size_ex_mem == 2'b01) begin
         w_be    = 4'b0011 << alu_out_ex_mem[1:0];
         w_wdata = {2{ram_write_data_ex_mem[15:0]}};
      end
   end

   always_comb begin
      w_byte = ram_rdata[{r_off, 3'b000} +: 8];
      w_half = ram_rdata[{r_off[1], 4'b0000} +: 16];
      if (r_size[1]) begin
         w_ext = ram_rdata;
      end else if (r_size[0]) begin
         w_ext = {{16{~r_uns & w_half[15]}}, w_half};
      end else begin
         w_ext = {{24{~r_uns & w_byte[7]}}, w_byte};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state           <= StIdle;
         r_cnt             <= '0;
         r_load            <= 1'b0;
         r_uns             <= 1'b0;
         r_size            <= 2'b00;
         r_off             <= 2'b00;
         ram_req           <= 1'b0;
         ram_we            <= 1'b0;
         ram_addr          <= '0;
         ram_be            <= 4'b0000;
         ram_wdata         <= 32'h0;
         ram_read_data_mem <= 32'h0;
         mem_bus_error     <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_start) begin
                  r_state   <= StWait;
                  r_cnt     <= '0;
                  r_load    <= MemRead_ex_mem;
                  r_uns     <= mem_unsigned_ex_mem;
                  r_size    <= mem_size_ex_mem;
                  r_off     <= alu_out_ex_mem[1:0];
                  ram_req   <= 1'b1;
                  ram_we    <= ~MemRead_ex_mem;
                  ram_addr  <= alu_out_ex_mem[ADDR_WIDTH+1:2];
                  ram_be    <= w_be;
                  ram_wdata <= w_wdata;
               end
            end
            StWait: begin
               r_cnt <= r_cnt + CNT_W'(1);
               // Ack takes priority over a timeout landing in the same cycle.
               if (ram_ack) begin
                  r_state <= StDone;
                  ram_req <= 1'b0;
                  if (r_load) begin
                     ram_read_data_mem <= w_ext;
                  end
               end else if (w_timeout) begin
                  r_state           <= StDone;
                  ram_req           <= 1'b0;
                  mem_bus_error     <= 1'b1;
                  ram_read_data_mem <= 32'h0;
               end
            end
            StDone: begin
               r_state       <= StIdle;
               r_cnt         <= '0;
               mem_bus_error <= 1'b0;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus random load/store traffic
// compared every cycle against a transaction-level timeline model.
module tb_mem_stage;

   localparam int AW = 30;
   localparam int TO = 16;

   logic          clk;
   logic          rst_n;
   logic          valid_ex_mem;
   logic          MemRead_ex_mem;
   logic          MemWrite_ex_mem;
   logic [1:0]    mem_size_ex_mem;
   logic          mem_unsigned_ex_mem;
   logic          halt_ex_mem;
   logic [31:0]   alu_out_ex_mem;
   logic [31:0]   ram_write_data_ex_mem;
   logic          ram_req;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [3:0]    ram_be;
   logic [31:0]   ram_wdata;
   logic          ram_ack;
   logic [31:0]   ram_rdata;
   logic [31:0]   ram_read_data_mem;
   logic          mem_stall;
   logic          mem_misaligned;
   logic          mem_bus_error;

   mem_stage #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .valid_ex_mem         (valid_ex_mem),
      .MemRead_ex_mem       (MemRead_ex_mem),
      .MemWrite_ex_mem      (MemWrite_ex_mem),
      .mem_size_ex_mem      (mem_size_ex_mem),
      .mem_unsigned_ex_mem  (mem_unsigned_ex_mem),
      .halt_ex_mem          (halt_ex_mem),
      .alu_out_ex_mem       (alu_out_ex_mem),
      .ram_write_data_ex_mem(ram_write_data_ex_mem),
      .ram_req              (ram_req),
      .ram_we               (ram_we),
      .ram_addr             (ram_addr),
      .ram_be               (ram_be),
      .ram_wdata            (ram_wdata),
      .ram_ack              (ram_ack),
      .ram_rdata            (ram_rdata),
      .ram_read_data_mem    (ram_read_data_mem),
      .mem_stall            (mem_stall),
      .mem_misaligned       (mem_misaligned),
      .mem_bus_error        (mem_bus_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Model expectations for the current cycle.
   bit            chk_en = 1'b0;
   logic          e_req, e_stall, e_mis, e_err, e_we;
   logic [AW-1:0] e_addr;
   logic [3:0]    e_be;
   logic [31:0]   e_wdata, e_data;
   logic [31:0]   m_data;

   // Snapshots of the last operation, used for literal checks.
   logic          s_mis0, s_stall0, s_we, s_err;
   logic [3:0]    s_be;
   logic [31:0]   s_wdata, s_done_data;
   int            s_reqcyc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("req", 32'(ram_req), 32'(e_req));
         chk("stall", 32'(mem_stall), 32'(e_stall));
         chk("misaligned", 32'(mem_misaligned), 32'(e_mis));
         chk("bus_error", 32'(mem_bus_error), 32'(e_err));
         chk("read_data_mem", ram_read_data_mem, e_data);
         if (e_req) begin
            chk("we", 32'(ram_we), 32'(e_we));
            chk("addr", 32'(ram_addr), 32'(e_addr));
            chk("be", 32'(ram_be), 32'(e_be));
            chk("wdata", ram_wdata, e_wdata);
         end
      end
   end

   function automatic logic [3:0] f_be(input logic [1:0] sz, input logic [1:0] off);
      if (sz == 2'd0) return 4'(1 << off);
      if (sz == 2'd1) return 4'(3 << off);
      return 4'hF;
   endfunction

   function automatic logic [31:0] f_wd(input logic [1:0] sz, input logic [31:0] d);
      if (sz == 2'd0) return (d & 32'hFF) * 32'h01010101;
      if (sz == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
      return d;
   endfunction

   function automatic logic [31:0] f_ext(input logic [1:0] sz, input logic uns,
                                         input logic [1:0] off, input logic [31:0] rd);
      logic [31:0] v;
      if (sz[1]) return rd;
      if (sz == 2'd1) begin
         v = (rd >> (16 * int'(off[1]))) & 32'hFFFF;
         if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
      end else begin
         v = (rd >> (8 * int'(off))) & 32'hFF;
         if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
      end
      return v;
   endfunction

   // One ex_mem instruction; ack_at = WAIT cycle of the ack (0 or >TO: never).
   task automatic op(input logic vld, ld, st, input logic [1:0] sz, input logic uns, hlt,
                     input logic [31:0] a, wd, rd, input int ack_at);
      logic mis, go, acked;
      mis = (sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'd0);
      go  = vld && (ld || st) && !hlt && !mis;
      valid_ex_mem = vld; MemRead_ex_mem = ld; MemWrite_ex_mem = st;
      mem_size_ex_mem = sz; mem_unsigned_ex_mem = uns; halt_ex_mem = hlt;
      alu_out_ex_mem = a; ram_write_data_ex_mem = wd;
      ram_ack = 1'($urandom_range(0, 1)); ram_rdata = $urandom;
      e_req = 1'b0; e_stall = go; e_mis = vld && (ld || st) && mis; e_err = 1'b0;
      e_data = m_data;
      #1;
      s_mis0 = mem_misaligned; s_stall0 = mem_stall; s_reqcyc = 0; s_err = 1'b0;
      @(posedge clk); #1;
      if (go) begin
         e_we = !ld; e_addr = a[31:2]; e_be = f_be(sz, a[1:0]); e_wdata = f_wd(sz, wd);
         acked = 1'b0;
         for (int k = 1; k <= TO; k++) begin
            ram_ack = (k == ack_at);
            ram_rdata = (k == ack_at) ? rd : $urandom;
            e_req = 1'b1; e_stall = 1'b1; e_mis = 1'b0;
            if (k == 1) begin
               s_be = ram_be; s_wdata = ram_wdata; s_we = ram_we;
            end
            s_reqcyc += int'(ram_req);
            @(posedge clk); #1;
            if (k == ack_at) begin
               acked = 1'b1;
               break;
            end
         end
         ram_ack = 1'($urandom_range(0, 1)); ram_rdata = $urandom;
         if (acked) begin
            if (ld) m_data = f_ext(sz, uns, a[1:0], rd);
         end else begin
            m_data = 32'h0;
            e_err  = 1'b1;
         end
         e_req = 1'b0; e_stall = 1'b0; e_data = m_data;
         s_err = mem_bus_error; s_done_data = ram_read_data_mem;
         @(posedge clk); #1;
         e_err = 1'b0;
      end
      valid_ex_mem = 1'b0; MemRead_ex_mem = 1'b0; MemWrite_ex_mem = 1'b0; ram_ack = 1'b0;
      e_req = 1'b0; e_stall = 1'b0; e_mis = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      valid_ex_mem = 1'b0; MemRead_ex_mem = 1'b0; MemWrite_ex_mem = 1'b0;
      mem_size_ex_mem = 2'd0; mem_unsigned_ex_mem = 1'b0; halt_ex_mem = 1'b0;
      alu_out_ex_mem = 32'h0; ram_write_data_ex_mem = 32'h0;
      ram_ack = 1'b0; ram_rdata = 32'h0;
      m_data = 32'h0;
      e_req = 1'b0; e_stall = 1'b0; e_mis = 1'b0; e_err = 1'b0; e_we = 1'b0;
      e_addr = '0; e_be = 4'h0; e_wdata = 32'h0; e_data = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", 32'(ram_req), 32'h0);
      chk("rst_we", 32'(ram_we), 32'h0);
      chk("rst_addr", 32'(ram_addr), 32'h0);
      chk("rst_be", 32'(ram_be), 32'h0);
      chk("rst_wdata", ram_wdata, 32'h0);
      chk("rst_data", ram_read_data_mem, 32'h0);
      chk("rst_err", 32'(mem_bus_error), 32'h0);
      rst_n = 1'b1;
      chk_en = 1'b1;

      // Directed cases with literal expectations.
      op(1, 1, 0, 2'd2, 0, 0, 32'h100, 32'h0, 32'h8899AABB, 1);
      chk("lw_lit", ram_read_data_mem, 32'h8899AABB);
      chk("lw_req_cycles", 32'(s_reqcyc), 32'd1);
      op(1, 1, 0, 2'd0, 0, 0, 32'h103, 32'h0, 32'h80FFFFFF, 2);
      chk("lb_lit", ram_read_data_mem, 32'hFFFFFF80);
      op(1, 1, 0, 2'd0, 1, 0, 32'h103, 32'h0, 32'h80FFFFFF, 1);
      chk("lbu_lit", ram_read_data_mem, 32'h00000080);
      op(1, 1, 0, 2'd1, 0, 0, 32'h102, 32'h0, 32'h80011234, 3);
      chk("lh_lit", ram_read_data_mem, 32'hFFFF8001);
      op(1, 0, 1, 2'd0, 0, 0, 32'h101, 32'h123456AB, 32'h0, 1);
      chk("sb_be_lit", 32'(s_be), 32'h2);
      chk("sb_wdata_lit", s_wdata, 32'hABABABAB);
      chk("sb_we_lit", 32'(s_we), 32'h1);
      chk("store_keeps_data", ram_read_data_mem, 32'hFFFF8001);
      op(1, 0, 1, 2'd1, 0, 0, 32'h102, 32'h123456AB, 32'h0, 2);
      chk("sh_be_lit", 32'(s_be), 32'hC);
      chk("sh_wdata_lit", s_wdata, 32'h56AB56AB);
      op(1, 1, 0, 2'd2, 0, 0, 32'h102, 32'h0, 32'h0, 1);
      chk("lw_mis_lit", 32'(s_mis0), 32'h1);
      chk("lw_mis_stall_lit", 32'(s_stall0), 32'h0);
      op(1, 1, 0, 2'd2, 0, 0, 32'h104, 32'h0, 32'h11223344, 0);
      chk("timeout_req_cycles", 32'(s_reqcyc), 32'd16);
      chk("timeout_err_lit", 32'(s_err), 32'h1);
      chk("timeout_data_lit", s_done_data, 32'h0);
      op(1, 1, 0, 2'd2, 0, 0, 32'h108, 32'h0, 32'hCAFEF00D, 16);
      chk("late_ack_err_lit", 32'(s_err), 32'h0);
      chk("late_ack_data_lit", s_done_data, 32'hCAFEF00D);
      op(1, 1, 0, 2'd2, 0, 1, 32'h10C, 32'h0, 32'h0, 1);
      chk("halt_stall_lit", 32'(s_stall0), 32'h0);

      // Reset in the middle of WAIT drops the request without a clock edge.
      chk_en = 1'b0;
      valid_ex_mem = 1'b1; MemRead_ex_mem = 1'b1; mem_size_ex_mem = 2'd2;
      halt_ex_mem = 1'b0; alu_out_ex_mem = 32'h200; ram_ack = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_reset_req", 32'(ram_req), 32'h1);
      valid_ex_mem = 1'b0; MemRead_ex_mem = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("async_reset_req", 32'(ram_req), 32'h0);
      chk("async_reset_stall", 32'(mem_stall), 32'h0);
      chk("async_reset_data", ram_read_data_mem, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_data = 32'h0;
      e_data = 32'h0; e_req = 1'b0; e_stall = 1'b0; e_mis = 1'b0; e_err = 1'b0;
      chk_en = 1'b1;
      op(1, 1, 0, 2'd2, 0, 0, 32'h204, 32'h0, 32'h5A5A1234, 2);
      chk("after_reset_lit", ram_read_data_mem, 32'h5A5A1234);

      // Random traffic.
      for (int n = 0; n < 300; n++) begin
         logic [1:0] kind;
         int ack_at;
         kind = 2'($urandom_range(0, 3));
         ack_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, TO + 1)
                                               : $urandom_range(1, 4);
         op(1'($urandom_range(0, 7) != 0), kind[0], kind[1], 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0), $urandom, $urandom,
            $urandom, ack_at);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
